// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, owner encoding
// and the latency-counter width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} arb_owner_t;

    function automatic int cnt_w(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Winner selection between fetch and data requesters.
// ARB_RR_EN: alternate winners on contention using ptr; otherwise DM always wins.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic dm_req,
`ifdef ARB_RR_EN
    input  logic ptr,
`endif
    output logic grant,
    output logic win_dm
);

    always_comb begin
        grant  = if_req | dm_req;
`ifdef ARB_RR_EN
        if (if_req && dm_req)
            win_dm = (ptr == OWN_DM);
        else
            win_dm = dm_req;
`else
        win_dm = dm_req;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port fixed-latency memory shared by instruction fetch and data access.
// Build option ARB_RR_EN enables round-robin on contention (default: DM priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,
    output logic                if_stall,
    input  logic                dm_read,
    input  logic                dm_write,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_done,
    output logic                dm_stall,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int CW = cnt_w(MEM_LAT);
    localparam int BW = DATA_W / 8;

    arb_state_t          state, state_nxt;
    arb_owner_t          owner;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BW-1:0]       be_q;
    logic                we_q;
    logic [CW-1:0]       cnt;
    logic [DATA_W-1:0]   if_rdata_q, dm_rdata_q;
    logic                dm_req, grant, win_dm;

    assign dm_req = dm_read | dm_write;

`ifdef ARB_RR_EN
    arb_owner_t ptr;

    arb_pick u_pick (
        .if_req (if_req),
        .dm_req (dm_req),
        .ptr    (ptr),
        .grant  (grant),
        .win_dm (win_dm)
    );

    // Pointer names who wins the next contention; uncontended grants leave it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= OWN_DM;
        else if (state == IDLE && if_req && dm_req)
            ptr <= win_dm ? OWN_IF : OWN_DM;
    end
`else
    arb_pick u_pick (
        .if_req (if_req),
        .dm_req (dm_req),
        .grant  (grant),
        .win_dm (win_dm)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A simultaneous read+write is taken as a store; reads carry no byte enables.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= OWN_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            cnt        <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (grant) begin
                    owner   <= win_dm ? OWN_DM : OWN_IF;
                    addr_q  <= win_dm ? dm_addr : if_addr;
                    we_q    <= win_dm & dm_write;
                    wdata_q <= win_dm ? dm_wdata : '0;
                    be_q    <= (win_dm && dm_write) ? dm_be : '0;
                end
                ISSUE: cnt <= CW'(MEM_LAT - 1);
                WAIT: begin
                    if (cnt != '0)
                        cnt <= cnt - CW'(1);
                    else if (!we_q) begin
                        if (owner == OWN_DM)
                            dm_rdata_q <= mem_rdata;
                        else
                            if_rdata_q <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_en    = (state == ISSUE);
        mem_we    = (state == ISSUE) & we_q;
        mem_wdata = (state == ISSUE) ? wdata_q : '0;
        mem_be    = (state == ISSUE) ? be_q : '0;
        mem_addr  = (state == ISSUE || state == WAIT) ? addr_q : '0;
        if_done   = (state == DONE) && (owner == OWN_IF);
        dm_done   = (state == DONE) && (owner == OWN_DM);
        if_rdata  = if_rdata_q;
        dm_rdata  = (dm_done && we_q) ? '0 : dm_rdata_q;
        if_stall  = if_req & ~if_done;
        dm_stall  = dm_req & ~dm_done;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: MEM_LAT=2 main instance plus a MEM_LAT=1 instance.
module tb_mem_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, dm_read, dm_write;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata, mem_rdata;
    logic [BW-1:0] dm_be;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic          if_done, if_stall, dm_done, dm_stall, mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_be;

    logic          l1_if_req;
    logic [AW-1:0] l1_if_addr;
    logic [DW-1:0] l1_if_rdata, l1_dm_rdata, l1_mem_wdata;
    logic          l1_if_done, l1_if_stall, l1_dm_done, l1_dm_stall, l1_mem_en, l1_mem_we;
    logic [AW-1:0] l1_mem_addr;
    logic [BW-1:0] l1_mem_be;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_stall(if_stall),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_rdata(dm_rdata),
        .dm_done(dm_done), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut_l1 (
        .clk(clk), .reset(reset),
        .if_req(l1_if_req), .if_addr(l1_if_addr), .if_rdata(l1_if_rdata),
        .if_done(l1_if_done), .if_stall(l1_if_stall),
        .dm_read(1'b0), .dm_write(1'b0), .dm_addr('0),
        .dm_wdata('0), .dm_be('0), .dm_rdata(l1_dm_rdata),
        .dm_done(l1_dm_done), .dm_stall(l1_dm_stall),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
        .mem_wdata(l1_mem_wdata), .mem_be(l1_mem_be), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        if_req = 0; dm_read = 0; dm_write = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_be = '0; mem_rdata = '0;
        l1_if_req = 0; l1_if_addr = '0;
        ticks(2);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_done", {30'd0, if_done, dm_done}, 32'd0);
        chk("rst_stall", {30'd0, if_stall, dm_stall}, 32'd0);
        chk("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
        chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
        reset = 1'b0;

        // single fetch
        tick();
        if_req = 1; if_addr = 9'h010; mem_rdata = '0;
        #1 chk("f_stall_T", {31'd0, if_stall}, 32'd1);
        tick();
        chk("f_mem_en_T1", {31'd0, mem_en}, 32'd1);
        chk("f_mem_addr_T1", {23'd0, mem_addr}, 32'h010);
        chk("f_mem_we_T1", {31'd0, mem_we}, 32'd0);
        tick();
        chk("f_mem_en_T2", {31'd0, mem_en}, 32'd0);
        chk("f_mem_addr_T2", {23'd0, mem_addr}, 32'h010);
        tick();
        mem_rdata = 32'hDEADBEEF;
        chk("f_stall_T3", {31'd0, if_stall}, 32'd1);
        chk("f_done_T3", {31'd0, if_done}, 32'd0);
        tick();
        chk("f_done_T4", {31'd0, if_done}, 32'd1);
        chk("f_rdata_T4", if_rdata, 32'hDEADBEEF);
        chk("f_stall_T4", {31'd0, if_stall}, 32'd0);
        if_req = 0; mem_rdata = '0;
        tick();
        chk("f_done_T5", {31'd0, if_done}, 32'd0);
        chk("f_rdata_hold", if_rdata, 32'hDEADBEEF);

        // store
        tick();
        dm_write = 1; dm_addr = 9'h020; dm_wdata = 32'h12345678; dm_be = 4'b0011;
        mem_rdata = 32'hFFFFFFFF;
        tick();
        chk("s_mem_en", {31'd0, mem_en}, 32'd1);
        chk("s_mem_we", {31'd0, mem_we}, 32'd1);
        chk("s_mem_be", {28'd0, mem_be}, 32'h3);
        chk("s_mem_wdata", mem_wdata, 32'h12345678);
        chk("s_mem_addr", {23'd0, mem_addr}, 32'h020);
        tick();
        chk("s_mem_en_T2", {30'd0, mem_en, mem_we}, 32'd0);
        ticks(2);
        chk("s_done", {31'd0, dm_done}, 32'd1);
        chk("s_rdata", dm_rdata, 32'd0);
        chk("s_stall", {31'd0, dm_stall}, 32'd0);
        dm_write = 0; dm_be = '0;
        tick();

        // contention: DM first under either arbitration (pointer starts at DM)
        tick();
        if_req = 1; if_addr = 9'h040; dm_read = 1; dm_addr = 9'h050;
        mem_rdata = 32'hAAAA5555;
        tick();
        chk("c1_mem_addr", {23'd0, mem_addr}, 32'h050);
        chk("c1_mem_be", {28'd0, mem_be}, 32'h0);
        ticks(3);
        chk("c1_dm_done", {31'd0, dm_done}, 32'd1);
        chk("c1_dm_rdata", dm_rdata, 32'hAAAA5555);
        chk("c1_if_wait", {30'd0, if_done, if_stall}, 32'd1);
        dm_read = 0; mem_rdata = 32'h13579BDF;
        ticks(2);
        chk("c1_if_issue", {22'd0, mem_en, mem_addr}, {22'd0, 1'b1, 9'h040});
        ticks(3);
        chk("c1_if_done", {31'd0, if_done}, 32'd1);
        chk("c1_if_rdata", if_rdata, 32'h13579BDF);
        if_req = 0;
        tick();

        // second contention: IF wins only with round-robin
        tick();
        if_req = 1; if_addr = 9'h060; dm_read = 1; dm_addr = 9'h070;
        mem_rdata = 32'h0F0F0F0F;
        tick();
`ifdef ARB_RR_EN
        chk("c2_first_addr", {23'd0, mem_addr}, 32'h060);
        ticks(3);
        chk("c2_first_done", {30'd0, if_done, dm_done}, 32'b10);
        if_req = 0;
        ticks(5);
        chk("c2_second_done", {30'd0, if_done, dm_done}, 32'b01);
        dm_read = 0;
`else
        chk("c2_first_addr", {23'd0, mem_addr}, 32'h070);
        ticks(3);
        chk("c2_first_done", {30'd0, if_done, dm_done}, 32'b01);
        dm_read = 0;
        ticks(5);
        chk("c2_second_done", {30'd0, if_done, dm_done}, 32'b10);
        if_req = 0;
`endif
        tick();

        // read and write together behave as a store
        tick();
        dm_read = 1; dm_write = 1; dm_addr = 9'h030; dm_wdata = 32'h0BADF00D; dm_be = 4'hF;
        mem_rdata = 32'h99999999;
        tick();
        chk("rw_mem_we", {31'd0, mem_we}, 32'd1);
        chk("rw_mem_addr", {23'd0, mem_addr}, 32'h030);
        chk("rw_mem_be", {28'd0, mem_be}, 32'hF);
        ticks(3);
        chk("rw_done", {31'd0, dm_done}, 32'd1);
        chk("rw_rdata", dm_rdata, 32'd0);
        dm_read = 0; dm_write = 0; dm_be = '0;
        tick();

        // reset during WAIT
        tick();
        if_req = 1; if_addr = 9'h015; mem_rdata = 32'h55555555;
        ticks(2);
        chk("r_in_wait", {23'd0, mem_addr}, 32'h015);
        reset = 1; if_req = 0;
        #1;
        chk("r_mem_addr", {23'd0, mem_addr}, 32'd0);
        chk("r_outs", {28'd0, mem_en, if_done, if_stall, dm_done}, 32'd0);
        tick();
        chk("r_no_done1", {31'd0, if_done}, 32'd0);
        reset = 0;
        tick();
        chk("r_no_done2", {31'd0, if_done}, 32'd0);
        tick();
        if_req = 1; if_addr = 9'h016; mem_rdata = 32'h77777777;
        ticks(4);
        chk("r_new_done", {31'd0, if_done}, 32'd1);
        chk("r_new_rdata", if_rdata, 32'h77777777);
        if_req = 0;
        tick();

        // MEM_LAT=1 instance
        tick();
        l1_if_req = 1; l1_if_addr = 9'h011; mem_rdata = '0;
        tick();
        chk("l1_mem_en", {22'd0, l1_mem_en, l1_mem_addr}, {22'd0, 1'b1, 9'h011});
        tick();
        mem_rdata = 32'hCAFEF00D;
        chk("l1_wait", {30'd0, l1_mem_en, l1_if_done}, 32'd0);
        tick();
        mem_rdata = '0;
        chk("l1_done", {31'd0, l1_if_done}, 32'd1);
        chk("l1_rdata", l1_if_rdata, 32'hCAFEF00D);
        l1_if_req = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
